// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access size codes, FSM states
// and the decode that classifies a request as erroneous.
package dm_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    function automatic logic dm_size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H, SZ_HU: return addr_lo[0];
            SZ_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic dm_access_err(input logic [2:0] size, input logic [1:0] addr_lo);
        return !dm_size_legal(size) || dm_misaligned(size, addr_lo);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU load/store port: request fields driven by the CPU, completion fields by memory.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, size, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/dm_load_align.sv
// Extracts a byte/half/word from a little-endian 32-bit word and sign/zero extends it.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        rdata    = '0;
        case (size)
            SZ_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   rdata = {24'h0, byte_sel};
            SZ_H:    rdata = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   rdata = {16'h0, half_sel};
            SZ_W:    rdata = word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: latches one request, waits LATENCY+1 cycles, then performs
// the little-endian access and pulses ready for one cycle.
//
// state | meaning
// IDLE  | no request held, accepting req
// WAIT  | request latched, counting down to the access
// RESP  | ready pulse; a held req is accepted back-to-back
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

    dm_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [2:0]       size_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_r;
    logic             ready_r;
    logic             err_r;
    logic             busy_r;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [31:0]      word;
    logic [31:0]      load_data;
    logic             access_err;
    logic             completing;
    logic             accept;
    logic             do_write;
    logic [3:0]       be;
    logic [31:0]      wlane;

    assign idx        = addr_q[IDX_W+1:2];
    assign word       = mem[idx];
    assign access_err = dm_access_err(size_q, addr_q[1:0]);
    assign completing = (state == WAIT) && (cnt == '0);
    assign accept     = bus.req && ((state == IDLE) || (state == RESP));
    assign do_write   = completing && we_q && !access_err;

    dm_load_align u_load_align (
        .word    (word),
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .rdata   (load_data)
    );

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        case (size_q)
            SZ_B: begin
                be             = 4'b0000;
                be[addr_q[1:0]] = 1'b1;
                wlane          = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            SZ_W: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
            default: begin
                be    = 4'b0000;
                wlane = wdata_q;
            end
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_r <= '0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            if (accept) begin
                we_q    <= bus.we;
                size_q  <= bus.size;
                addr_q  <= bus.addr[IDX_W+1:0];
                wdata_q <= bus.wdata;
                cnt     <= CNT_LOAD;
                busy_r  <= 1'b1;
                err_r   <= 1'b0;
                state   <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (completing) begin
                            state   <= RESP;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                            err_r   <= access_err;
                            rdata_r <= (we_q || access_err) ? 32'h0 : load_data;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.busy  = busy_r;

endmodule
